// File: rtl/hht_rd_arbiter.sv
// hht_rd_arbiter: round-robin, burst-bounded read arbiter sharing one
// single-port data memory between the column-index and vector-value fetchers.
// Ports:
//   Clk, Rst          clock, async active-low reset
//   req0/1, addr0/1   read requests and addresses from the two requesters
//   gnt0/1            combinational one-hot grant
//   rvalid0/1, rdata0/1  registered per-owner read responses
//   mem_rd, mem_addr  registered memory read command
//   mem_rdata         memory read data, valid MEM_LAT cycles after mem_rd
//   busy              a granted read has not yet produced its rvalid
module hht_rd_arbiter #(
  parameter int MEM_LAT   = 0,
  parameter int MAX_BURST = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int         DEPTH = MEM_LAT + 1;
  localparam logic [3:0] MAXB  = 4'(MAX_BURST);

  logic             last;
  logic [3:0]       burst;
  logic             pick1;
  logic             gnt_any;
  logic [DEPTH-1:0] tag_v;
  logic [DEPTH-1:0] tag_o;

  // When both request, the incumbent keeps the port until its burst
  // budget is spent; then the other side takes over.
  always_comb begin
    pick1   = (burst < MAXB) ? last : ~last;
    gnt1    = req1 & (~req0 | pick1);
    gnt0    = req0 & ~gnt1;
    gnt_any = gnt0 | gnt1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last  <= 1'b0;
      burst <= 4'd0;
    end else if (gnt_any) begin
      if (gnt1 == last) begin
        burst <= (burst >= MAXB) ? MAXB : burst + 4'd1;
      end else begin
        last  <= gnt1;
        burst <= 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mem_rd   <= 1'b0;
      mem_addr <= 32'd0;
    end else begin
      mem_rd <= gnt_any;
      if (gnt_any) begin
        mem_addr <= gnt1 ? addr1 : addr0;
      end
    end
  end

  // Stage 0 lines up with mem_rd; the last stage lines up with the
  // cycle in which mem_rdata is valid for that read.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= gnt_any;
      tag_o[0] <= gnt1;
      for (int i = 1; i < DEPTH; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= 32'd0;
      rdata1  <= 32'd0;
    end else begin
      rvalid0 <= tag_v[DEPTH-1] & ~tag_o[DEPTH-1];
      rvalid1 <= tag_v[DEPTH-1] & tag_o[DEPTH-1];
      if (tag_v[DEPTH-1] & ~tag_o[DEPTH-1]) begin
        rdata0 <= mem_rdata;
      end
      if (tag_v[DEPTH-1] & tag_o[DEPTH-1]) begin
        rdata1 <= mem_rdata;
      end
    end
  end

  assign busy = |tag_v;

endmodule
